spi_eeprom_engine: RTL
======================

Name: spi_eeprom_engine

Overview:
- SPI serializer stage directly downstream of the Wishbone register block. It accepts one decoded EEPROM command per handshake and drives the 25AA010A-class serial EEPROM pins.
- Builds complete mode-0 frames: opcode, address, then data or dummy byte.
- Returns read and status bytes to the register block.
- Its pins connect straight to the EEPROM (MOSI/SCK/CS_N/WP_N/HOLD_N/RESET, MISO).

Parameters:
- CLK_DIV, 4: SCK half-period in CLK_I cycles; legal range 1..255.
- DIV_W, 8: width of the divider counter; must hold CLK_DIV-1.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command offered by register block
- CMD_READY  out  1  engine can accept a command
- CMD_OP  in  2  00 WREN, 01 WRITE, 10 READ, 11 RDSR
- CMD_ADDR  in  8  byte address; bit 7 is sent as given
- CMD_DATA  in  8  write data (WRITE only)
- RSP_VALID  out  1  one-cycle pulse, RSP_DATA updated
- RSP_DATA  out  8  last byte received (READ data or status)
- BUSY  out  1  high whenever the state is not IDLE
- SPI_MOSI  out  1  serial data to the EEPROM
- SPI_CLK  out  1  SCK, idles low
- SPI_CS_N  out  1  chip select, active low
- SPI_WP_N  out  1  write protect; constant 1 after reset
- SPI_HOLD_N  out  1  hold; constant 1 after reset
- SPI_RESET  out  1  memory reset; high during reset and for the first clock after release, then 0
- SPI_MISO  in  1  serial data from the EEPROM

Behaviour:
- Reset values while RST_I=0 (asynchronous):
  - CS_N=1, SPI_CLK=0, MOSI=0.
  - CMD_READY=0, BUSY=0, RSP_VALID=0, RSP_DATA=0x00.
  - WP_N=1, HOLD_N=1, SPI_RESET=1.
  - State IDLE.
- After reset release, CMD_READY=1 in IDLE only.
- Handshake: a command is accepted on a rising edge where CMD_VALID & CMD_READY.
  - OP, ADDR and DATA are latched on that edge; the inputs are don't-care afterwards.
  - CMD_READY drops on the next cycle.
- Frames are sent MSB first:
  - WREN: 0x06, 8 bits.
  - WRITE: 0x02, ADDR, DATA, 24 bits.
  - READ: 0x03, ADDR, 0x00, 24 bits; the last 8 MISO bits are captured.
  - RDSR: 0x05, 0x00, 16 bits; the last 8 MISO bits are captured.
- States: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> GAP -> IDLE.
- IDLE: CS_N=1, SCK=0.
- CS_SETUP: CS_N=0 and MOSI=frame MSB on entry; lasts CLK_DIV cycles.
- SHIFT: lasts N_bits*2*CLK_DIV cycles.
  - SCK toggles every CLK_DIV cycles, starting low.
  - MISO is sampled on each SCK rising edge.
  - MOSI shifts to the next bit on each SCK falling edge.
  - SHIFT exits on the falling edge of the final bit, leaving SCK=0.
- CS_HOLD: CS_N=0, SCK=0; lasts CLK_DIV cycles.
- GAP: CS_N=1; lasts CLK_DIV cycles.
  - On entry to GAP, for READ/RDSR only: RSP_DATA is loaded and RSP_VALID pulses for 1 cycle.
- CS_N low time = (2 + 2*N_bits)*CLK_DIV cycles.
- Accept-to-next-READY = (3 + 2*N_bits)*CLK_DIV + 1 cycles.
- RSP_DATA holds its value until the next READ/RDSR completes; WREN and WRITE never change it.
- CMD_VALID held high in IDLE issues back-to-back commands; a GAP of at least CLK_DIV cycles always separates frames.
- RST_I asserted mid-frame: the frame is aborted immediately (CS_N=1, SCK=0) with no RSP_VALID. The EEPROM discards the partial frame.
- CMD_OP is latched at accept; no illegal codes exist.
- The divider counter resets to 0 at every state entry.

Optional Feature:
- SPI_WIP_POLL_EN defined:
  - After a WRITE frame's GAP, the engine enters POLL instead of IDLE.
  - POLL issues internal RDSR frames, each followed by GAP, until status bit 0 (WIP) reads 0; then it returns to IDLE.
  - CMD_READY stays 0 and BUSY stays 1 throughout POLL.
  - Poll results do not pulse RSP_VALID, but the final status byte is loaded into RSP_DATA.
- SPI_WIP_POLL_EN undefined:
  - WRITE returns to IDLE after GAP; software polls with RDSR.

Test Plan:
- Reset: hold RST_I=0 for 10 cycles with CMD_VALID=1. Required: CS_N=1, SCK=0, CMD_READY=0, SPI_RESET=1. After release: SPI_RESET=0 one cycle later and CMD_READY=1.
- WREN, CLK_DIV=2. Required: CS_N low exactly 36 cycles; 8 SCK pulses; MOSI bits 0,0,0,0,0,1,1,0 at successive rising edges; CMD_READY back after 39 cycles.
- WRITE ADDR=0x05 DATA=0xA5, then READ ADDR=0x05 with the EEPROM model in the loop. Required: 24 SCK pulses per frame; RSP_VALID pulses once; RSP_DATA=0xA5. With SPI_WIP_POLL_EN, the READ is not accepted until WIP clears.
- RDSR after WREN. Required: 16 SCK pulses; RSP_DATA bit 1 (WEL) = 1; RSP_VALID pulse width is 1 cycle.
- Abort: assert RST_I during the 10th SCK high phase of a WRITE. Required: CS_N=1 and SCK=0 in the same timestep; no RSP_VALID. A subsequent READ of that address returns the old data.
- Back-to-back: CMD_VALID held with WREN then RDSR, CLK_DIV=1. Required: CS_N high for at least 1 cycle between frames; both commands accepted exactly once.

Source files
------------

// File: rtl/spi_eeprom_engine_if.sv
// Command/response bus between the Wishbone register block and the SPI EEPROM engine.
`timescale 1ns/1ps
interface spi_eeprom_engine_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic [7:0] CMD_ADDR;
  logic [7:0] CMD_DATA;
  logic       RSP_VALID;
  logic [7:0] RSP_DATA;
  logic       BUSY;

  modport master (
    output CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA,
    input  CMD_READY, RSP_VALID, RSP_DATA, BUSY
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_ADDR, CMD_DATA,
    output CMD_READY, RSP_VALID, RSP_DATA, BUSY
  );
endinterface

// File: rtl/spi_eeprom_engine.sv
// SPI mode-0 frame engine for a 25AA010A-class EEPROM: one command per handshake,
// opcode/address/data framing, read and status byte return.
// Optional macro SPI_WIP_POLL_EN: after WRITE, poll RDSR internally until WIP clears.
`timescale 1ns/1ps
module spi_eeprom_engine #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DIV_W   = 8
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  spi_eeprom_engine_if.slave bus,
  output logic               SPI_MOSI,
  output logic               SPI_CLK,
  output logic               SPI_CS_N,
  output logic               SPI_WP_N,
  output logic               SPI_HOLD_N,
  output logic               SPI_RESET,
  input  logic               SPI_MISO
);

  localparam int unsigned FRAME_W = 24;
  localparam int unsigned BIT_W   = 5;
  localparam logic [1:0] OP_WREN  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RDSR  = 2'b11;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD, ST_GAP, ST_POLL
  } state_e;

  // Left-aligned frame; trailing zeros keep MOSI low once all bits are shifted out.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0] op,
                                                     input logic [7:0] addr,
                                                     input logic [7:0] data);
    case (op)
      OP_WREN:  build_frame = {8'h06, 16'h0000};
      OP_WRITE: build_frame = {8'h02, addr, data};
      OP_READ:  build_frame = {8'h03, addr, 8'h00};
      default:  build_frame = {8'h05, 16'h0000};
    endcase
  endfunction

  function automatic logic [BIT_W-1:0] last_bit(input logic [1:0] op);
    case (op)
      OP_WREN: last_bit = BIT_W'(7);
      OP_RDSR: last_bit = BIT_W'(15);
      default: last_bit = BIT_W'(23);
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [7:0]         rx_q, rx_d;
  logic [1:0]         op_q, op_d;
  logic               poll_q, poll_d;
  logic               sck_q, sck_d;
  logic               cs_n_q, cs_n_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic               wp_n_q, wp_n_d;
  logic               hold_n_q, hold_n_d;
  logic               spi_reset_q, spi_reset_d;
  logic               accept_c;
  logic               div_end_c;

  assign accept_c  = bus.CMD_VALID & cmd_ready_q;
  assign div_end_c = (div_q == DIV_LAST);

  // Next-state and datapath: divider-paced frame sequencing.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    op_d        = op_q;
    poll_d      = poll_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    wp_n_d      = 1'b1;
    hold_n_d    = 1'b1;
    spi_reset_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        sck_d  = 1'b0;
        div_d  = '0;
        if (accept_c) begin
          op_d      = bus.CMD_OP;
          tx_d      = build_frame(bus.CMD_OP, bus.CMD_ADDR, bus.CMD_DATA);
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          state_d   = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        div_d = div_q + DIV_W'(1);
        if (div_end_c) begin
          div_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        div_d = div_q + DIV_W'(1);
        if (div_end_c) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[6:0], SPI_MISO};
          end else begin
            tx_d = {tx_q[FRAME_W-2:0], 1'b0};
            if (bit_cnt_q == last_bit(op_q)) begin
              state_d = ST_CS_HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end
      end
      ST_CS_HOLD: begin
        div_d = div_q + DIV_W'(1);
        if (div_end_c) begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          state_d = ST_GAP;
          // Internal polls only publish the final (WIP clear) status, silently.
          if (op_q[1]) begin
            if (!poll_q) begin
              rsp_data_d  = rx_q;
              rsp_valid_d = 1'b1;
            end else if (!rx_q[0]) begin
              rsp_data_d = rx_q;
            end
          end
        end
      end
      ST_GAP: begin
        div_d = div_q + DIV_W'(1);
        if (div_end_c) begin
          div_d = '0;
`ifdef SPI_WIP_POLL_EN
          if (op_q == OP_WRITE || (poll_q && rx_q[0])) begin
            state_d = ST_POLL;
            poll_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            poll_d  = 1'b0;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_POLL: begin
`ifdef SPI_WIP_POLL_EN
        op_d      = OP_RDSR;
        tx_d      = build_frame(OP_RDSR, 8'h00, 8'h00);
        bit_cnt_d = '0;
        div_d     = '0;
        cs_n_d    = 1'b0;
        state_d   = ST_CS_SETUP;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_q == ST_IDLE) && !accept_c;
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      op_q        <= OP_WREN;
      poll_q      <= 1'b0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      wp_n_q      <= 1'b1;
      hold_n_q    <= 1'b1;
      spi_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      op_q        <= op_d;
      poll_q      <= poll_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      wp_n_q      <= wp_n_d;
      hold_n_q    <= hold_n_d;
      spi_reset_q <= spi_reset_d;
    end
  end

  assign bus.CMD_READY = cmd_ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_DATA  = rsp_data_q;
  assign bus.BUSY      = busy_q;
  assign SPI_MOSI      = tx_q[FRAME_W-1];
  assign SPI_CLK       = sck_q;
  assign SPI_CS_N      = cs_n_q;
  assign SPI_WP_N      = wp_n_q;
  assign SPI_HOLD_N    = hold_n_q;
  assign SPI_RESET     = spi_reset_q;

endmodule
